// File: rtl/as2650_pkg.sv
// Shared definitions for the AS2650 user project: default status port
// address, well-known stage codes and the packed status pin layout.
package as2650_pkg;

  localparam logic [7:0] STATUS_ADDR_DEFAULT = 8'hF0;

  // Stage codes the test firmware uses to mark the start and a pass.
  localparam logic [4:0] STAGE_PASS  = 5'd30;
  localparam logic [4:0] STAGE_BEGIN = 5'd31;

  // Layout of the six status pins: sticky error on top, stage below.
  typedef struct packed {
    logic       err;
    logic [4:0] stage;
  } status_t;

endpackage : as2650_pkg

// File: rtl/as2650_status_fifo.sv
// Small synchronous FIFO holding queued stage codes. Pointers wrap naturally
// and the count register is one bit wider than the pointers so that the
// full and empty states stay distinct.
module as2650_status_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 5,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full only succeeds if a pop frees the slot in the same cycle,
  // and a pop of an empty FIFO is ignored.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array: written at the tail, no reset needed since count guards reads.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : as2650_status_fifo

// File: rtl/as2650_status_port.sv
// Memory-mapped test-status port. CPU writes to PORT_ADDR queue a stage code
// that is shown on the pins for at least HOLD_CYCLES clocks; the error bit
// bypasses the queue and is sticky until reset.
module as2650_status_port
  import as2650_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR   = STATUS_ADDR_DEFAULT,
  parameter int         DEPTH       = 4,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       io_wr,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic       io_ready,
  output logic [5:0] status_o,
  output logic [5:0] status_oeb,
  output logic       overflow_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic              hit;
  logic              push;
  logic              pop;
  logic              hold_zero;
  logic [HOLD_W-1:0] hold_cnt;
  logic [4:0]        stage_q;
  logic              err_q;
  logic              overflow_q;
  logic [4:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;
  logic [AW:0]       fifo_count_unused;
  logic [1:0]        wdata_unused;
  status_t           status_w;

  // Bits 6:5 of the write data carry nothing; the fill level is only of
  // interest when probing the FIFO itself.
  assign wdata_unused      = io_wdata[6:5];
  assign fifo_count_unused = fifo_count;

  assign hit       = io_wr & (io_addr == PORT_ADDR);
  assign hold_zero = (hold_cnt == '0);
  assign pop       = ~fifo_empty & hold_zero;
  assign io_ready  = ~fifo_full | pop;
  assign push      = hit & io_ready;

  as2650_status_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clock (wb_clk_i),
    .reset (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (io_wdata[4:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage display and hold timer: a pop shows the head and restarts the hold,
  // otherwise the timer counts down to zero and the last stage stays visible.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stage_q  <= '0;
      hold_cnt <= '0;
    end else if (pop) begin
      stage_q  <= fifo_head;
      hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
    end else if (!hold_zero) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Sticky flags: error from any hit with bit 7 set, even a dropped one, and
  // overflow from any hit that found no room.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (hit && io_wdata[7]) begin
        err_q <= 1'b1;
      end
      if (hit && !io_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign status_w   = '{err: err_q, stage: stage_q};
  assign status_o   = status_w;
  assign status_oeb = 6'b0;
  assign overflow_o = overflow_q;

endmodule : as2650_status_port
